// File: rtl/transport_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing one 8-bit transport TX byte path among N_REQ sources.
// Latency: one cycle from accept (valid&ready) to registered data/flag; arbitration takes one IDLE cycle.
// Backpressure: ready only toward the granted source while cl0_s=1; grant held for the whole packet.
module transport_tx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int MAX_PKT  = 64,
  parameter int IDLE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cl0_s,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           transport_layer_data_in,
  output logic                 transport_data_flag,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 pkt_trunc
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);

  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(N_REQ);
  localparam logic [IW-1:0] LAST_REQ = IW'(N_REQ - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT - 1);
  localparam logic [2:0]    GAP_LAST = 3'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   grant_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [2:0]      gap_cnt_q;
  logic [7:0]      data_q;
  logic            flag_q;
  logic            trunc_q;

  logic            arb_found;
  logic [IW:0]     arb_cand;
  logic [IW-1:0]   grant_d;
  logic [IW-1:0]   rr_ptr_d;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            accept;
  logic            end_by_cnt;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_cand  = '0;
    grant_d   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_cand = {1'b0, rr_ptr_q} + (IW + 1)'(k);
      if (arb_cand >= NREQ_W) begin
        arb_cand = arb_cand - NREQ_W;
      end
      if (!arb_found && req_valid[arb_cand[IW-1:0]]) begin
        arb_found = 1'b1;
        grant_d   = arb_cand[IW-1:0];
      end
    end
  end

  assign rr_ptr_d = (grant_d == LAST_REQ) ? '0 : grant_d + 1'b1;

  // Mux the granted requester's byte, valid and last marker.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*8 +: 8];
      end
    end
  end

  // Ready goes only to the granted source, and only while the link is in CL0.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_SEND && cl0_s) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign accept     = (state_q == ST_SEND) && cl0_s && sel_valid;
  assign end_by_cnt = (byte_cnt_q == LAST_CNT);

  // Scheduler FSM with registered byte/flag/truncation outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      flag_q  <= 1'b0;
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cl0_s && arb_found) begin
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= '0;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            data_q     <= sel_data;
            flag_q     <= 1'b1;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (sel_last || end_by_cnt) begin
              // A count-limited byte that also carries last is a normal end.
              trunc_q   <= end_by_cnt && !sel_last;
              gap_cnt_q <= '0;
              state_q   <= (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign transport_layer_data_in = data_q;
  assign transport_data_flag     = flag_q;
  assign pkt_trunc               = trunc_q;
  assign grant_id                = 3'(grant_q);
  assign busy                    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_transport_tx_scheduler.sv
// Bench for transport_tx_scheduler: packet sources fed from queues, output checked against a packet-level model.
// Latency: outputs sampled on the falling edge, one cycle after the accepting rising edge.
// Backpressure: sources hold their head byte until valid&ready; random bubbles and CL0 drops.
module tb_transport_tx_scheduler;

  localparam int N   = 4;
  localparam int MAXP = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           cl0_s;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     transport_layer_data_in;
  logic           transport_data_flag;
  logic [2:0]     grant_id;
  logic           busy;
  logic           pkt_trunc;

  transport_tx_scheduler #(.N_REQ(N), .MAX_PKT(MAXP), .IDLE_GAP(1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cl0_s                   (cl0_s),
    .req_valid               (req_valid),
    .req_data                (req_data),
    .req_last                (req_last),
    .req_ready               (req_ready),
    .transport_layer_data_in (transport_layer_data_in),
    .transport_data_flag     (transport_data_flag),
    .grant_id                (grant_id),
    .busy                    (busy),
    .pkt_trunc               (pkt_trunc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] g;
    logic       t;
    logic       first;
  } exp_t;

  // Source byte queues: {last, data}.
  logic [8:0] src [N][$];
  exp_t       exp_q [$];
  int         model_rr;
  int         model_trunc;
  int         seen_trunc;
  int         vectors;
  int         miscompares;
  int         zero_run;
  bit         seen_any;

  // Packet-level reference: pick next non-empty source round-robin, emit up to MAXP bytes.
  task automatic build_model();
    logic [8:0] cp [N][$];
    int g, cnt;
    bit found, done;
    logic [8:0] b;
    exp_t e;
    for (int i = 0; i < N; i++) cp[i] = src[i];
    forever begin
      found = 0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && cp[(model_rr + k) % N].size() > 0) begin
          found = 1;
          g = (model_rr + k) % N;
        end
      end
      if (!found) break;
      model_rr = (g + 1) % N;
      cnt = 0;
      done = 0;
      while (!done) begin
        b = cp[g].pop_front();
        cnt++;
        e.d = b[7:0];
        e.g = 3'(g);
        e.t = !b[8] && (cnt == MAXP);
        e.first = (cnt == 1);
        if (e.t) model_trunc++;
        exp_q.push_back(e);
        done = b[8] || (cnt == MAXP);
      end
    end
  endtask

  task automatic load_pkt(input int s, input int len, input bit with_last);
    logic [7:0] d;
    for (int b = 1; b <= len; b++) begin
      d = 8'($urandom);
      src[s].push_back({with_last && (b == len), d});
    end
  endtask

  function automatic bit sources_empty();
    bit r = 1;
    for (int i = 0; i < N; i++) if (src[i].size() > 0) r = 0;
    return r;
  endfunction

  // One clock: check last cycle's outputs, drive sources, pop on handshake.
  task automatic step(input bit cl0, input bit bub);
    logic [N-1:0] fired;
    exp_t e;
    @(negedge clk);
    if (transport_data_flag) begin
      vectors++;
      if (pkt_trunc) seen_trunc++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: got data=%h gid=%0d, none expected", transport_layer_data_in, grant_id);
      end else begin
        e = exp_q.pop_front();
        if ({transport_layer_data_in, grant_id, pkt_trunc} !== {e.d, e.g, e.t}) begin
          miscompares++;
          $display("FAIL byte_check: got data=%h gid=%0d trunc=%b, want data=%h gid=%0d trunc=%b",
                   transport_layer_data_in, grant_id, pkt_trunc, e.d, e.g, e.t);
        end
        if (e.first && seen_any) begin
          vectors++;
          if (zero_run < 2) begin
            miscompares++;
            $display("FAIL pkt_gap: got %0d idle cycles, want >= 2", zero_run);
          end
        end
      end
      zero_run = 0;
      seen_any = 1;
    end else begin
      zero_run++;
      vectors++;
      if (pkt_trunc !== 1'b0) begin
        miscompares++;
        $display("FAIL trunc_without_flag: got pkt_trunc=%b, want 0", pkt_trunc);
      end
    end
    cl0_s = cl0;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0 && !(bub && busy && grant_id == 3'(i) && $urandom_range(3) == 0)) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src[i][0][7:0];
        req_last[i]         = src[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
    #1;
    vectors++;
    if ((!cl0 && req_ready !== '0) || $countones(req_ready) > 1) begin
      miscompares++;
      $display("FAIL ready_gate: got req_ready=%b with cl0_s=%b, want one-hot or zero and zero when cl0_s=0", req_ready, cl0);
    end
    fired = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < N; i++) if (fired[i]) void'(src[i].pop_front());
  endtask

  task automatic drain(input int cl0_pct, input bit bub, input int max_cyc);
    int n = 0;
    while ((exp_q.size() > 0 || !sources_empty()) && n < max_cyc) begin
      step($urandom_range(99) < cl0_pct, bub);
      n++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    vectors++;
    if (exp_q.size() != 0 || !sources_empty()) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d bytes still expected after %0d cycles, want 0", exp_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cl0_s = 1'b1;
    @(posedge clk);
    #2;
    vectors++;
    if ({transport_layer_data_in, transport_data_flag, grant_id, busy, pkt_trunc} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h flag=%b gid=%0d busy=%b trunc=%b, want all 0",
               transport_layer_data_in, transport_data_flag, grant_id, busy, pkt_trunc);
    end
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 0", req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    req_valid = '0;
    model_rr = 0;
    seen_any = 0;
    zero_run = 0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_packet();
    logic busy_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    src[0].push_back({1'b0, 8'hA1});
    src[0].push_back({1'b0, 8'hA2});
    src[0].push_back({1'b1, 8'hA3});
    build_model();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      #2;
      vectors++;
      if (busy !== busy_exp[c] || grant_id !== 3'd0) begin
        miscompares++;
        $display("FAIL single_busy c%0d: got busy=%b gid=%0d, want busy=%b gid=0", c, busy, grant_id, busy_exp[c]);
      end
    end
    drain(100, 0, 50);
  endtask

  task automatic test_round_robin();
    load_pkt(0, 1, 1);
    load_pkt(0, 1, 1);
    load_pkt(1, 1, 1);
    load_pkt(2, 1, 1);
    load_pkt(3, 1, 1);
    build_model();
    drain(100, 0, 100);
  endtask

  task automatic test_cl0_gate();
    load_pkt(1, 3, 1);
    build_model();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0);
      #2;
      vectors++;
      if (req_ready !== '0 || transport_data_flag !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL cl0_idle: got ready=%b flag=%b busy=%b, want 0 0 0", req_ready, transport_data_flag, busy);
      end
    end
    step(1'b1, 1'b0);
    #2;
    vectors++;
    if (grant_id !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cl0_grant: got gid=%0d busy=%b, want gid=1 busy=1", grant_id, busy);
    end
    drain(100, 0, 50);
  endtask

  task automatic test_truncation();
    int t0;
    t0 = seen_trunc;
    model_trunc = 0;
    load_pkt(2, 70, 1);
    load_pkt(3, 64, 1);
    build_model();
    drain(100, 0, 400);
    vectors++;
    if (seen_trunc - t0 != model_trunc || model_trunc != 1) begin
      miscompares++;
      $display("FAIL trunc_count: got %0d pulses, want %0d (model) and 1", seen_trunc - t0, model_trunc);
    end
  endtask

  task automatic test_cl0_stall();
    load_pkt(1, 10, 1);
    build_model();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0);
      #2;
      vectors++;
      if (req_ready !== '0 || transport_data_flag !== 1'b0 || busy !== 1'b1 || grant_id !== 3'd1) begin
        miscompares++;
        $display("FAIL cl0_stall c%0d: got ready=%b flag=%b busy=%b gid=%0d, want 0 0 1 1",
                 c, req_ready, transport_data_flag, busy, grant_id);
      end
    end
    drain(100, 0, 100);
  endtask

  task automatic test_random_traffic();
    int t0;
    t0 = seen_trunc;
    model_trunc = 0;
    for (int p = 0; p < 24; p++) begin
      load_pkt($urandom_range(N - 1), (p == 0) ? MAXP : $urandom_range(80, 1), 1);
    end
    build_model();
    drain(80, 1, 20000);
    vectors++;
    if (seen_trunc - t0 != model_trunc) begin
      miscompares++;
      $display("FAIL random_trunc_count: got %0d, want %0d", seen_trunc - t0, model_trunc);
    end
  endtask

  task automatic test_reset_mid_packet();
    load_pkt(2, 20, 1);
    build_model();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    do_reset();
    load_pkt(1, 1, 1);
    load_pkt(3, 1, 1);
    build_model();
    drain(100, 0, 100);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_rr = 0;
    model_trunc = 0;
    seen_trunc = 0;
    zero_run = 0;
    seen_any = 0;
    reset = 1'b1;
    cl0_s = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    test_reset();
    test_single_packet();
    do_reset();
    test_round_robin();
    test_cl0_gate();
    test_truncation();
    test_cl0_stall();
    test_random_traffic();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
